fk_hop_seq: RTL and testbench

- Parametrised successor to the fixed page/page-scan advance-hop controller.
- Sequences a one-hot "next-frequency" token through NSTG link-controller substates, one stage ahead of the real substate, so the RF synthesiser can begin its PLL setup early.
- Adds configurable depth, per-stage half-slot advance, step-back retry with a limit, and parametrised N/E hop counters.
- Sits between the link-controller substate FSM and the hop-selection kernel.

---
 rtl/fk_hop_seq_if.sv | 40 ++++
 rtl/fk_hop_seq.sv | 131 +++++++++++++
 tb/tb_fk_hop_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fk_hop_seq_if.sv
// Signal bundle between the link-controller substate FSM, the hop-selection kernel and fk_hop_seq.
// master = substate/kernel side driving qualifiers, slave = fk_hop_seq.
interface fk_hop_seq_if #(
    parameter int unsigned NSTG   = 6,
    parameter int unsigned NCNT_W = 6,
    parameter int unsigned ECNT_W = 5,
    parameter int unsigned TO_W   = 8
);
    logic              fkset_p;
    logic              txbit_period;
    logic              rxbit_period;
    logic              half_tslot_p;
    logic              tslot_p;
    logic              start_p;
    logic [NSTG-1:0]   stg_act;
    logic [NSTG-1:0]   stg_ok;
    logic [NSTG-1:0]   stg_fail;
    logic              ecnt_clr;
    logic              ecnt_inc;
    logic [TO_W-1:0]   to_slots;
    logic [NSTG-1:0]   fk_stage;
    logic              fk_any;
    logic [NCNT_W-1:0] ncnt;
    logic [ECNT_W-1:0] ecnt;
    logic [1:0]        retry_cnt;
    logic              done_p;
    logic              abort_p;

    modport master (
        output fkset_p, txbit_period, rxbit_period, half_tslot_p, tslot_p, start_p,
               stg_act, stg_ok, stg_fail, ecnt_clr, ecnt_inc, to_slots,
        input  fk_stage, fk_any, ncnt, ecnt, retry_cnt, done_p, abort_p
    );

    modport slave (
        input  fkset_p, txbit_period, rxbit_period, half_tslot_p, tslot_p, start_p,
               stg_act, stg_ok, stg_fail, ecnt_clr, ecnt_inc, to_slots,
        output fk_stage, fk_any, ncnt, ecnt, retry_cnt, done_p, abort_p
    );
endinterface

// File: rtl/fk_hop_seq.sv
// Advance-hop token sequencer: one-hot next-frequency token running one stage ahead of the substate.
// Optional idle-timeout abort is built only when FKSEQ_TIMEOUT_EN is defined.
module fk_hop_seq #(
    parameter int unsigned     NSTG      = 6,
    parameter logic [NSTG-1:0] HALF_MASK = 6'b100000,
    parameter int unsigned     NCNT_W    = 6,
    parameter int unsigned     ECNT_W    = 5,
    parameter int unsigned     RETRY_MAX = 3,
    parameter int unsigned     TO_W      = 8
) (
    input  logic        clk_6M,
    input  logic        rst,
    fk_hop_seq_if.slave bus
);
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [1:0]      RMAX    = 2'(RETRY_MAX);
    localparam logic [NSTG-1:0] STG_GT0 = {{(NSTG-1){1'b1}}, 1'b0};

    state_t            r_state, w_state_nxt;
    logic [NSTG-1:0]   r_stage, w_stage_nxt;
    logic [NCNT_W-1:0] r_ncnt, w_ncnt_nxt;
    logic [ECNT_W-1:0] r_ecnt;
    logic [1:0]        r_retry, w_retry_nxt;
    logic              r_done, w_done_nxt;
    logic              r_abort, w_abort_nxt;
    logic              w_tok_chg;
    logic              w_fk_chg;
    logic              w_adv;
    logic              w_fail;
    logic              w_to_hit;
    logic [NSTG-1:0]   w_chg, w_chg_up, w_ok_v, w_fail_v;

    assign w_fk_chg = bus.fkset_p & ~(bus.txbit_period | bus.rxbit_period);
    assign w_chg    = (HALF_MASK & {NSTG{bus.half_tslot_p}}) | (~HALF_MASK & {NSTG{w_fk_chg}});

    // Edge that lets stage i move on: entry edge of stage i+1, or fk_chg_p for the final stage.
    assign w_chg_up = {w_fk_chg, w_chg[NSTG-1:1]};
    assign w_ok_v   = r_stage & bus.stg_act & bus.stg_ok & w_chg_up;
    assign w_fail_v = r_stage & bus.stg_act & bus.stg_fail & ~bus.stg_ok & STG_GT0 & {NSTG{w_fk_chg}};
    assign w_adv    = |w_ok_v;
    assign w_fail   = |w_fail_v;

`ifdef FKSEQ_TIMEOUT_EN
    logic [TO_W-1:0] r_idle, w_idle_inc;

    assign w_idle_inc = (r_idle == '1) ? r_idle : r_idle + 1'b1;
    assign w_to_hit   = (r_state == ST_RUN) && (bus.to_slots != '0) && bus.tslot_p
                        && (w_idle_inc >= bus.to_slots);

    always_ff @(posedge clk_6M) begin
        if (rst || w_tok_chg || (r_state != ST_RUN)) begin
            r_idle <= '0;
        end else if (bus.tslot_p) begin
            r_idle <= w_idle_inc;
        end
    end
`else
    logic w_unused_to;

    assign w_unused_to = ^bus.to_slots;
    assign w_to_hit    = 1'b0;
`endif

    always_comb begin
        w_stage_nxt = r_stage;
        w_ncnt_nxt  = r_ncnt;
        w_retry_nxt = r_retry;
        w_done_nxt  = 1'b0;
        w_abort_nxt = 1'b0;
        w_tok_chg   = 1'b0;
        if (bus.start_p) begin
            w_stage_nxt = NSTG'(1);
            w_ncnt_nxt  = NCNT_W'(1);
            w_retry_nxt = '0;
            w_tok_chg   = 1'b1;
        end else if ((w_fail && (r_retry >= RMAX)) || w_to_hit) begin
            w_stage_nxt = '0;
            w_abort_nxt = 1'b1;
            w_tok_chg   = 1'b1;
        end else if (w_fail) begin
            w_stage_nxt = r_stage >> 1;
            w_retry_nxt = r_retry + 2'd1;
            w_tok_chg   = 1'b1;
        end else if (w_adv) begin
            // Shifting out of the top stage is completion.
            w_stage_nxt = r_stage << 1;
            w_tok_chg   = 1'b1;
            if (r_stage[NSTG-1]) begin
                w_done_nxt = 1'b1;
            end else begin
                w_ncnt_nxt = r_ncnt + 1'b1;
            end
        end
        w_state_nxt = (|w_stage_nxt) ? ST_RUN : ST_IDLE;
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_stage <= '0;
            r_ncnt  <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
            r_ncnt  <= w_ncnt_nxt;
            r_retry <= w_retry_nxt;
            r_done  <= w_done_nxt;
            r_abort <= w_abort_nxt;
        end
    end

    always_ff @(posedge clk_6M) begin
        if (rst || bus.ecnt_clr) begin
            r_ecnt <= '0;
        end else if (bus.ecnt_inc && bus.tslot_p) begin
            r_ecnt <= r_ecnt + 1'b1;
        end
    end

    assign bus.fk_stage  = r_stage;
    assign bus.fk_any    = (r_state == ST_RUN);
    assign bus.ncnt      = r_ncnt;
    assign bus.ecnt      = r_ecnt;
    assign bus.retry_cnt = r_retry;
    assign bus.done_p    = r_done;
    assign bus.abort_p   = r_abort;
endmodule

// File: tb/tb_fk_hop_seq.sv
// Directed bench for fk_hop_seq: each driven cycle queues its hand-computed outputs,
// a negedge monitor pops and compares them one cycle later.
module tb_fk_hop_seq;
    typedef struct {
        int unsigned cyc;
        logic [5:0]  stage;
        logic [5:0]  ncnt;
        logic [4:0]  ecnt;
        logic [1:0]  retry;
        logic        done;
        logic        abort;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    exp_t        q[$];

    fk_hop_seq_if #(.NSTG(6), .NCNT_W(6), .ECNT_W(5), .TO_W(8)) bus ();

    fk_hop_seq #(
        .NSTG(6), .HALF_MASK(6'b100000), .NCNT_W(6), .ECNT_W(5), .RETRY_MAX(3), .TO_W(8)
    ) dut (
        .clk_6M(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                chk("stale_expect", cyc, e.cyc);
            end else begin
                chk("fk_stage", 32'(bus.fk_stage), 32'(e.stage));
                chk("fk_any", 32'(bus.fk_any), 32'(|e.stage));
                chk("ncnt", 32'(bus.ncnt), 32'(e.ncnt));
                chk("ecnt", 32'(bus.ecnt), 32'(e.ecnt));
                chk("retry_cnt", 32'(bus.retry_cnt), 32'(e.retry));
                chk("done_p", 32'(bus.done_p), 32'(e.done));
                chk("abort_p", 32'(bus.abort_p), 32'(e.abort));
            end
        end
    end

    // Queue the expected post-edge outputs, let the edge happen, drop one-cycle inputs.
    task automatic tick(input logic [5:0] s, input logic [5:0] n, input logic [4:0] e,
                        input logic [1:0] r, input logic d, input logic a);
        exp_t x;
        x.cyc = cyc + 1; x.stage = s; x.ncnt = n; x.ecnt = e; x.retry = r; x.done = d; x.abort = a;
        q.push_back(x);
        @(negedge clk);
        bus.fkset_p = 1'b0; bus.txbit_period = 1'b0; bus.rxbit_period = 1'b0;
        bus.half_tslot_p = 1'b0; bus.tslot_p = 1'b0; bus.start_p = 1'b0;
        bus.stg_act = '0; bus.stg_ok = '0; bus.stg_fail = '0;
        bus.ecnt_clr = 1'b0; bus.ecnt_inc = 1'b0;
    endtask

    task automatic mv(input int k, input logic fk, input logic h, input logic okb, input logic fl);
        bus.stg_act      = 6'(1 << k);
        bus.stg_ok       = okb ? 6'(1 << k) : 6'd0;
        bus.stg_fail     = fl ? 6'(1 << k) : 6'd0;
        bus.fkset_p      = fk;
        bus.half_tslot_p = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.fkset_p = 1'b0; bus.txbit_period = 1'b0; bus.rxbit_period = 1'b0;
        bus.half_tslot_p = 1'b0; bus.tslot_p = 1'b0; bus.start_p = 1'b0;
        bus.stg_act = '0; bus.stg_ok = '0; bus.stg_fail = '0;
        bus.ecnt_clr = 1'b0; bus.ecnt_inc = 1'b0; bus.to_slots = '0;
        @(negedge clk);
        tick(6'd0, 6'd0, 5'd0, 2'd0, 0, 0);
        tick(6'd0, 6'd0, 5'd0, 2'd0, 0, 0);
        rst = 1'b0;

        // idle token ignores movement inputs
        mv(0, 1, 1, 1, 1);
        tick(6'd0, 6'd0, 5'd0, 2'd0, 0, 0);

        // full walk, then completion
        bus.start_p = 1'b1;
        tick(6'b000001, 6'd1, 5'd0, 2'd0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            mv(k, 1, 1, 1, 0);
            tick(6'(1 << (k + 1)), 6'(k + 2), 5'd0, 2'd0, 0, 0);
        end
        mv(5, 1, 0, 1, 0);
        tick(6'd0, 6'd6, 5'd0, 2'd0, 1, 0);
        tick(6'd0, 6'd6, 5'd0, 2'd0, 0, 0);

        // tx/rx windows block fk_chg_p; ok beats fail
        bus.start_p = 1'b1;
        tick(6'b000001, 6'd1, 5'd0, 2'd0, 0, 0);
        mv(0, 1, 0, 1, 0); tick(6'b000010, 6'd2, 5'd0, 2'd0, 0, 0);
        mv(1, 1, 0, 1, 0); tick(6'b000100, 6'd3, 5'd0, 2'd0, 0, 0);
        mv(2, 1, 0, 1, 0); bus.txbit_period = 1'b1; tick(6'b000100, 6'd3, 5'd0, 2'd0, 0, 0);
        mv(2, 1, 0, 1, 0); bus.rxbit_period = 1'b1; tick(6'b000100, 6'd3, 5'd0, 2'd0, 0, 0);
        mv(2, 1, 0, 1, 0); tick(6'b001000, 6'd4, 5'd0, 2'd0, 0, 0);
        mv(3, 1, 0, 1, 1); tick(6'b010000, 6'd5, 5'd0, 2'd0, 0, 0);

        // step-back retries then abort on the fourth failure
        mv(4, 1, 0, 0, 1); tick(6'b001000, 6'd5, 5'd0, 2'd1, 0, 0);
        mv(3, 1, 0, 1, 0); tick(6'b010000, 6'd6, 5'd0, 2'd1, 0, 0);
        mv(4, 1, 0, 0, 1); tick(6'b001000, 6'd6, 5'd0, 2'd2, 0, 0);
        mv(3, 1, 0, 1, 0); tick(6'b010000, 6'd7, 5'd0, 2'd2, 0, 0);
        mv(4, 1, 0, 0, 1); tick(6'b001000, 6'd7, 5'd0, 2'd3, 0, 0);
        mv(3, 1, 0, 1, 0); tick(6'b010000, 6'd8, 5'd0, 2'd3, 0, 0);
        mv(4, 1, 0, 0, 1); tick(6'd0, 6'd8, 5'd0, 2'd3, 0, 1);
        tick(6'd0, 6'd8, 5'd0, 2'd3, 0, 0);

        // stage 0 ignores fail, mismatched act ignored, half-slot entry of stage 5
        bus.start_p = 1'b1;
        tick(6'b000001, 6'd1, 5'd0, 2'd0, 0, 0);
        mv(0, 1, 0, 0, 1); tick(6'b000001, 6'd1, 5'd0, 2'd0, 0, 0);
        mv(1, 1, 0, 1, 0); tick(6'b000001, 6'd1, 5'd0, 2'd0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            mv(k, 1, 0, 1, 0);
            tick(6'(1 << (k + 1)), 6'(k + 2), 5'd0, 2'd0, 0, 0);
        end
        mv(4, 1, 0, 1, 0); tick(6'b010000, 6'd5, 5'd0, 2'd0, 0, 0);
        mv(4, 0, 1, 1, 0); tick(6'b100000, 6'd6, 5'd0, 2'd0, 0, 0);
        mv(5, 0, 1, 1, 0); tick(6'b100000, 6'd6, 5'd0, 2'd0, 0, 0);
        mv(5, 1, 0, 1, 0); tick(6'd0, 6'd6, 5'd0, 2'd0, 1, 0);

        // E counter: 40 slots wraps to 8, clear beats increment
        for (int i = 0; i < 40; i++) begin
            bus.ecnt_inc = 1'b1; bus.tslot_p = 1'b1;
            tick(6'd0, 6'd6, 5'(i + 1), 2'd0, 0, 0);
        end
        bus.ecnt_clr = 1'b1; bus.ecnt_inc = 1'b1; bus.tslot_p = 1'b1;
        tick(6'd0, 6'd6, 5'd0, 2'd0, 0, 0);
        bus.ecnt_inc = 1'b1; bus.tslot_p = 1'b1;
        tick(6'd0, 6'd6, 5'd1, 2'd0, 0, 0);

        // restart mid-sequence wins over advance
        bus.start_p = 1'b1;
        tick(6'b000001, 6'd1, 5'd1, 2'd0, 0, 0);
        mv(0, 1, 0, 1, 0); tick(6'b000010, 6'd2, 5'd1, 2'd0, 0, 0);
        mv(1, 1, 0, 1, 0); bus.start_p = 1'b1; tick(6'b000001, 6'd1, 5'd1, 2'd0, 0, 0);

        // idle timeout at stage 1
        bus.to_slots = 8'd4;
        mv(0, 1, 0, 1, 0); tick(6'b000010, 6'd2, 5'd1, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            bus.tslot_p = 1'b1;
            tick(6'b000010, 6'd2, 5'd1, 2'd0, 0, 0);
        end
        bus.tslot_p = 1'b1;
`ifdef FKSEQ_TIMEOUT_EN
        tick(6'd0, 6'd2, 5'd1, 2'd0, 0, 1);
        tick(6'd0, 6'd2, 5'd1, 2'd0, 0, 0);
`else
        tick(6'b000010, 6'd2, 5'd1, 2'd0, 0, 0);
        bus.tslot_p = 1'b1;
        tick(6'b000010, 6'd2, 5'd1, 2'd0, 0, 0);
`endif
        bus.to_slots = 8'd0;
        bus.start_p = 1'b1;
        tick(6'b000001, 6'd1, 5'd1, 2'd0, 0, 0);
        for (int i = 0; i < 300; i++) begin
            bus.tslot_p = 1'b1;
            tick(6'b000001, 6'd1, 5'd1, 2'd0, 0, 0);
        end

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
